gpu_pixel_arbiter: RTL

- Shares the single pixel-write port of gpu_memcontroller between the four draw engines: line, fill, arc and circle.
- Engines may run concurrently, each presenting pixels with a valid/ready handshake.
- A round-robin arbiter accepts at most one pixel per cycle into a small FIFO. The FIFO drains to the memory controller under memory backpressure.
- Frame-flush requests are held off until every accepted pixel has been written.

---
 rtl/gpu_pixel_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/gpu_pixel_arbiter.sv
// Round-robin arbiter that merges the four draw engines' pixel streams into one
// small FIFO feeding the memory controller's pixel-write port, with flush ordering.

`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_pixel_arbiter #(
  parameter int N_REQ  = 4,
  parameter int X_BITS = `WIDTH_BITS,
  parameter int Y_BITS = `HEIGHT_BITS,
  parameter int C_BITS = `CHANNEL_BITS,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*X_BITS-1:0]   req_x_i,
  input  logic [N_REQ*Y_BITS-1:0]   req_y_i,
  input  logic [N_REQ*3*C_BITS-1:0] req_rgb_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic                      pix_valid_o,
  output logic [X_BITS-1:0]         pix_x_o,
  output logic [Y_BITS-1:0]         pix_y_o,
  output logic [3*C_BITS-1:0]       pix_rgb_o,
  input  logic                      mem_ready_i,
  input  logic                      flush_req_i,
  output logic                      flush_o,
  output logic                      busy_o,
  output logic [1:0]                dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on the same port's data, valid never waits on ready.

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PIX_W = X_BITS + Y_BITS + 3 * C_BITS;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    PULSE = 2'd2
  } flush_state_e;

  flush_state_e      state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              busy_q;
  logic [PIX_W-1:0]  mem_q [DEPTH];

  logic              grant_ok;
  logic              gnt_found;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  cand;
  logic              push;
  logic              pop;
  logic [PIX_W-1:0]  push_data;

  // Reset gates the grant so no engine sees ready while the block is held in reset.
  assign grant_ok = n_rst && (count_q != FULL_CNT) && (state_q == IDLE);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = IDX_W'((int'(rr_q) + off) % N_REQ);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign push = grant_ok && gnt_found;
  assign pop  = (count_q != '0) && mem_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (push) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  assign push_data = {req_x_i[int'(gnt_idx)*X_BITS +: X_BITS],
                      req_y_i[int'(gnt_idx)*Y_BITS +: Y_BITS],
                      req_rgb_i[int'(gnt_idx)*3*C_BITS +: 3*C_BITS]};

  always_comb begin
    rr_d = rr_q;
    if (push) begin
      rr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rr_q    <= rr_d;
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign pix_valid_o = (count_q != '0);
  assign {pix_x_o, pix_y_o, pix_rgb_o} = mem_q[rd_ptr_q];

  // Flush waits in DRAIN until every accepted pixel has left the FIFO.
  always_comb begin
    state_d = state_q;
    flush_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == '0) begin
          state_d = PULSE;
        end
      end
      PULSE: begin
        flush_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (count_d != '0) || (state_d != IDLE);
    end
  end

  assign busy_o      = busy_q;
  assign dbg_state_o = state_q;

endmodule
